// File: rtl/i2c_cmd_arbiter_if.sv
// i2c_cmd_arbiter_if: requester, response and I2C-master signals of the command arbiter
interface i2c_cmd_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [13:0] req_addr;
  logic [1:0]  req_rw;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_nack;
  logic        rsp_timeout;
  logic        m_enable;
  logic        m_readwrite;
  logic [6:0]  m_addr;
  logic [7:0]  m_wdata;
  logic        m_busy;
  logic        m_done;
  logic        m_ack;
  logic [7:0]  m_rdata;
  logic        arb_busy;
  modport slave (
    input  req_valid, req_addr, req_rw, req_wdata, m_busy, m_done, m_ack, m_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
           m_enable, m_readwrite, m_addr, m_wdata, arb_busy
  );
  modport master (
    output req_valid, req_addr, req_rw, req_wdata, m_busy, m_done, m_ack, m_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
           m_enable, m_readwrite, m_addr, m_wdata, arb_busy
  );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin arbiter of two command requesters onto one I2C master; define I2C_ARB_TIMEOUT_EN to build the WAIT watchdog
module i2c_cmd_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic clk,
  input logic rst_n,
  i2c_cmd_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
  state_t      state;
  logic        rr_last;
  logic        cur;
  logic        gnt;
  logic        expired;
  logic [6:0]  addr_q;
  logic        rw_q;
  logic [7:0]  wdata_q;
  logic [1:0]  rv_q;
  logic [7:0]  rdata_q;
  logic        nack_q;
  logic        to_q;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  assign gnt = (bus.req_valid == 2'b11) ? ~rr_last : bus.req_valid[1];
  assign bus.req_ready = (rst_n && state == IDLE && |bus.req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign bus.m_enable = (state == LAUNCH) && !bus.m_busy;
  assign bus.arb_busy = (state != IDLE);
  assign bus.m_addr = addr_q;
  assign bus.m_readwrite = rw_q;
  assign bus.m_wdata = wdata_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_nack = nack_q;
  assign bus.rsp_timeout = to_q;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  // watchdog counts WAIT cycles; held at zero elsewhere so it starts clean on WAIT entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo_cnt <= '0;
    else tmo_cnt <= (state == WAIT) ? tmo_cnt + 1'b1 : '0;
  assign expired = (state == WAIT) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign expired = 1'b0;
`endif
  // arbitration FSM: accept one command, launch it, wait for completion, strobe the response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      cur     <= 1'b0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rv_q    <= '0;
      rdata_q <= '0;
      nack_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      rv_q <= 2'b00;
      case (state)
        IDLE:
          if (|bus.req_valid) begin
            cur     <= gnt;
            addr_q  <= gnt ? bus.req_addr[13:7] : bus.req_addr[6:0];
            rw_q    <= bus.req_rw[gnt];
            wdata_q <= gnt ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
            state   <= LAUNCH;
          end
        LAUNCH:
          if (!bus.m_busy) state <= WAIT;
        WAIT:
          if (bus.m_done) begin
            rdata_q <= bus.m_rdata;
            nack_q  <= bus.m_ack;
            to_q    <= 1'b0;
            rv_q    <= cur ? 2'b10 : 2'b01;
            state   <= RESP;
          end else if (expired) begin
            rdata_q <= '0;
            nack_q  <= 1'b1;
            to_q    <= 1'b1;
            rv_q    <= cur ? 2'b10 : 2'b01;
            state   <= RESP;
          end
        RESP: begin
          rr_last <= cur;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: randomized self-checking bench with a transaction-level round-robin model
module tb_i2c_cmd_arbiter;
  logic clk;
  logic rst_n;
  int n_checks;
  int n_pass;
  int mdl_last;
  i2c_cmd_arbiter_if bus ();
  i2c_cmd_arbiter #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] outs;
  assign outs = {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_nack, bus.rsp_timeout,
                 bus.m_enable, bus.m_readwrite, bus.m_addr, bus.m_wdata, bus.arb_busy};
  logic [1:0] o_ready, o_rsp, o_pre_valid;
  logic       o_pre_busy, o_en, o_en_early, o_stray, o_rw, o_nack, o_to;
  logic [6:0] o_addr;
  logic [7:0] o_wdata, o_rdata;

  function automatic int mdl_grant(input logic [1:0] v);
    if (v == 2'b11) return 1 - mdl_last;
    return v[1] ? 1 : 0;
  endfunction

  task automatic do_txn(input logic [1:0] v, input logic [13:0] a, input logic [1:0] rw,
                        input logic [15:0] wd, input int busy, input int dly,
                        input logic ack, input logic [7:0] rd, input bit keep);
    bus.req_valid = v; bus.req_addr = a; bus.req_rw = rw; bus.req_wdata = wd;
    @(negedge clk);
    o_pre_valid = bus.rsp_valid; o_pre_busy = bus.arb_busy; o_ready = bus.req_ready;
    @(posedge clk); #1;
    if (!keep) bus.req_valid = 2'b00;
    bus.req_addr = 14'($urandom); bus.req_rw = 2'($urandom); bus.req_wdata = 16'($urandom);
    o_stray = 0; o_en_early = 0;
    bus.m_busy = (busy > 0);
    for (int i = 0; i < busy; i++) begin
      @(negedge clk);
      o_en_early |= bus.m_enable; o_stray |= (|bus.req_ready) | (|bus.rsp_valid);
      @(posedge clk); #1;
    end
    bus.m_busy = 0;
    @(negedge clk);
    o_en = bus.m_enable; o_addr = bus.m_addr; o_rw = bus.m_readwrite; o_wdata = bus.m_wdata;
    o_stray |= (|bus.req_ready) | (|bus.rsp_valid);
    @(posedge clk); #1;
    bus.m_busy = 1;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      o_en_early |= bus.m_enable; o_stray |= (|bus.req_ready) | (|bus.rsp_valid);
      @(posedge clk); #1;
    end
    bus.m_done = 1; bus.m_ack = ack; bus.m_rdata = rd;
    @(negedge clk);
    o_stray |= (|bus.req_ready) | (|bus.rsp_valid);
    @(posedge clk); #1;
    bus.m_done = 0; bus.m_busy = 0; bus.m_ack = 1'($urandom); bus.m_rdata = 8'($urandom);
    @(negedge clk);
    o_rsp = bus.rsp_valid; o_rdata = bus.rsp_rdata; o_nack = bus.rsp_nack; o_to = bus.rsp_timeout;
    o_stray |= |bus.req_ready;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; bus.req_valid = 2'b11; bus.m_done = 1; bus.m_ack = 1; bus.m_rdata = 8'hFF;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (outs !== 32'h0) $display("FAIL reset_outs: got %h want 0", outs); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 2'b00) $display("FAIL reset_ready: got %b want 00", bus.req_ready); else n_pass++;
    bus.m_done = 0; bus.req_valid = 0;
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk);
    n_checks++; if (outs !== 32'h0) $display("FAIL reset_release_outs: got %h want 0", outs); else n_pass++;
    @(posedge clk); #1;
    mdl_last = 1;
  endtask

  task automatic test_basic_write();
    do_txn(2'b01, {7'h12, 7'h39}, 2'b10, {8'h3C, 8'hA5}, 0, 2, 1'b0, 8'h77, 0);
    n_checks++; if (o_ready !== 2'b01) $display("FAIL basic_ready: got %b want 01", o_ready); else n_pass++;
    n_checks++; if (o_en !== 1'b1 || o_en_early !== 1'b0) $display("FAIL basic_enable: got %b/%b want 1/0", o_en, o_en_early); else n_pass++;
    n_checks++; if (o_addr !== 7'h39 || o_rw !== 1'b0 || o_wdata !== 8'hA5) $display("FAIL basic_cmd: got %h/%b/%h want 39/0/a5", o_addr, o_rw, o_wdata); else n_pass++;
    n_checks++; if (o_rsp !== 2'b01 || o_nack !== 1'b0 || o_to !== 1'b0) $display("FAIL basic_rsp: got %b/%b/%b want 01/0/0", o_rsp, o_nack, o_to); else n_pass++;
    n_checks++; if (o_stray !== 1'b0) $display("FAIL basic_stray: got %b want 0", o_stray); else n_pass++;
    mdl_last = 0;
  endtask

  task automatic test_round_robin();
    logic [13:0] a; logic [1:0] rw; logic [15:0] wd; logic [7:0] rd; logic ack;
    logic [1:0] want; int g;
    rst_n = 0; #1; @(posedge clk); #1; rst_n = 1; mdl_last = 1;
    for (int k = 0; k < 4; k++) begin
      a = 14'($urandom); rw = 2'($urandom); wd = 16'($urandom); rd = 8'($urandom); ack = 1'($urandom);
      g = k % 2; want = (g == 1) ? 2'b10 : 2'b01;
      do_txn(2'b11, a, rw, wd, k, 1, ack, rd, 1);
      n_checks++; if (o_ready !== want) $display("FAIL rr_grant%0d: got %b want %b", k, o_ready, want); else n_pass++;
      n_checks++; if (o_rsp !== want) $display("FAIL rr_rsp%0d: got %b want %b", k, o_rsp, want); else n_pass++;
      n_checks++; if (o_addr !== a[g*7 +: 7] || o_wdata !== wd[g*8 +: 8] || o_rw !== rw[g]) $display("FAIL rr_cmd%0d: got %h/%h/%b want %h/%h/%b", k, o_addr, o_wdata, o_rw, a[g*7 +: 7], wd[g*8 +: 8], rw[g]); else n_pass++;
      if (k > 0) begin
        n_checks++; if (o_pre_valid !== 2'b00 || o_pre_busy !== 1'b0) $display("FAIL rr_idle%0d: got %b/%b want 00/0", k, o_pre_valid, o_pre_busy); else n_pass++;
      end
      mdl_last = g;
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_busy_read();
    logic [13:0] a;
    a = 14'($urandom);
    do_txn(2'b10, a, 2'b10, 16'($urandom), 5, 1, 1'b1, 8'h5C, 0);
    n_checks++; if (o_ready !== 2'b10) $display("FAIL busy_ready: got %b want 10", o_ready); else n_pass++;
    n_checks++; if (o_en_early !== 1'b0 || o_en !== 1'b1) $display("FAIL busy_enable: got early %b fall %b want 0/1", o_en_early, o_en); else n_pass++;
    n_checks++; if (o_rw !== 1'b1 || o_addr !== a[13:7]) $display("FAIL busy_cmd: got %b/%h want 1/%h", o_rw, o_addr, a[13:7]); else n_pass++;
    n_checks++; if (o_rsp !== 2'b10 || o_rdata !== 8'h5C || o_nack !== 1'b1) $display("FAIL busy_rsp: got %b/%h/%b want 10/5c/1", o_rsp, o_rdata, o_nack); else n_pass++;
    mdl_last = 1;
  endtask

  task automatic test_drop();
    logic [1:0] want;
    bus.req_valid = 2'b01;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 2'b01) $display("FAIL drop_ready: got %b want 01", bus.req_ready); else n_pass++;
    #1; bus.req_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (bus.arb_busy !== 1'b0 || bus.m_enable !== 1'b0) $display("FAIL drop_idle: got %b/%b want 0/0", bus.arb_busy, bus.m_enable); else n_pass++;
    @(posedge clk); #1;
    want = (mdl_grant(2'b11) == 1) ? 2'b10 : 2'b01;
    do_txn(2'b11, 14'($urandom), 2'($urandom), 16'($urandom), 0, 0, 1'b0, 8'($urandom), 0);
    n_checks++; if (o_ready !== want || o_rsp !== want) $display("FAIL drop_next: got %b/%b want %b", o_ready, o_rsp, want); else n_pass++;
    mdl_last = mdl_grant(2'b11);
  endtask

  task automatic test_timeout();
    int found;
    logic ack;
`ifdef I2C_ARB_TIMEOUT_EN
    ack = 1'($urandom);
    do_txn(2'b01, 14'($urandom), 2'($urandom), 16'($urandom), 0, 7, ack, 8'hC3, 0);
    n_checks++; if (o_rsp !== 2'b01 || o_to !== 1'b0 || o_nack !== ack || o_rdata !== 8'hC3) $display("FAIL tmo_done_prio: got %b/%b/%b/%h want 01/0/%b/c3", o_rsp, o_to, o_nack, o_rdata, ack); else n_pass++;
    mdl_last = 0;
    bus.req_valid = 2'b01;
    @(negedge clk); @(posedge clk); #1;
    bus.req_valid = 2'b00; bus.m_busy = 0;
    @(posedge clk); #1;
    found = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) begin
        found = k; o_rsp = bus.rsp_valid; o_to = bus.rsp_timeout; o_nack = bus.rsp_nack; o_rdata = bus.rsp_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++; if (found != 8) $display("FAIL tmo_latency: got %0d want 8", found); else n_pass++;
    n_checks++; if (o_rsp !== 2'b01 || o_to !== 1'b1 || o_nack !== 1'b1 || o_rdata !== 8'h00) $display("FAIL tmo_rsp: got %b/%b/%b/%h want 01/1/1/00", o_rsp, o_to, o_nack, o_rdata); else n_pass++;
    @(posedge clk); #1;
    mdl_last = 0;
`else
    ack = 1'b0;
    bus.req_valid = 2'b01;
    @(negedge clk); @(posedge clk); #1;
    bus.req_valid = 2'b00; bus.m_busy = 0;
    @(posedge clk); #1;
    found = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.arb_busy !== 1'b1 || bus.rsp_valid !== 2'b00) found++;
      @(posedge clk); #1;
    end
    n_checks++; if (found != 0) $display("FAIL tmo_wait_hold: got %0d bad cycles want 0", found); else n_pass++;
    bus.m_done = 1; bus.m_ack = ack; bus.m_rdata = 8'h44;
    @(posedge clk); #1; bus.m_done = 0;
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_timeout !== 1'b0 || bus.rsp_rdata !== 8'h44) $display("FAIL tmo_late_done: got %b/%b/%h want 01/0/44", bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata); else n_pass++;
    @(posedge clk); #1;
    mdl_last = 0;
`endif
  endtask

  task automatic test_random();
    logic [1:0] v, rw, want; logic [13:0] a; logic [15:0] wd; logic [7:0] rd; logic ack; int g;
    for (int k = 0; k < 24; k++) begin
      v = 2'($urandom_range(1, 3)); a = 14'($urandom); rw = 2'($urandom); wd = 16'($urandom);
      rd = 8'($urandom); ack = 1'($urandom);
      g = mdl_grant(v); want = (g == 1) ? 2'b10 : 2'b01;
      do_txn(v, a, rw, wd, $urandom_range(0, 3), $urandom_range(0, 4), ack, rd, 1'($urandom));
      n_checks++; if (o_ready !== want || o_pre_busy !== 1'b0 || o_pre_valid !== 2'b00) $display("FAIL rnd_accept%0d: got %b/%b/%b want %b/0/00", k, o_ready, o_pre_busy, o_pre_valid, want); else n_pass++;
      n_checks++; if (o_en !== 1'b1 || o_en_early !== 1'b0 || o_stray !== 1'b0) $display("FAIL rnd_launch%0d: got %b/%b/%b want 1/0/0", k, o_en, o_en_early, o_stray); else n_pass++;
      n_checks++; if (o_addr !== a[g*7 +: 7] || o_rw !== rw[g] || o_wdata !== wd[g*8 +: 8]) $display("FAIL rnd_cmd%0d: got %h/%b/%h want %h/%b/%h", k, o_addr, o_rw, o_wdata, a[g*7 +: 7], rw[g], wd[g*8 +: 8]); else n_pass++;
      n_checks++; if (o_rsp !== want || o_rdata !== rd || o_nack !== ack || o_to !== 1'b0) $display("FAIL rnd_rsp%0d: got %b/%h/%b/%b want %b/%h/%b/0", k, o_rsp, o_rdata, o_nack, o_to, want, rd, ack); else n_pass++;
      mdl_last = g;
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_reset_mid();
    int bad;
    bus.req_valid = 2'b10;
    @(negedge clk); @(posedge clk); #1;
    bus.req_valid = 2'b00; bus.m_busy = 0;
    repeat (3) begin @(posedge clk); #1; end
    #2; rst_n = 0; #1;
    n_checks++; if (outs !== 32'h0) $display("FAIL midrst_outs: got %h want 0", outs); else n_pass++;
    @(posedge clk); #1; rst_n = 1;
    bus.m_done = 1; bus.m_ack = 1; bus.m_rdata = 8'hEE;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 2'b00 || bus.arb_busy !== 1'b0) bad++;
      @(posedge clk); #1; bus.m_done = 0;
    end
    n_checks++; if (bad != 0) $display("FAIL midrst_ignore_done: got %0d bad cycles want 0", bad); else n_pass++;
    mdl_last = 1;
    do_txn(2'b11, 14'($urandom), 2'($urandom), 16'($urandom), 0, 1, 1'b0, 8'($urandom), 0);
    n_checks++; if (o_ready !== 2'b01 || o_rsp !== 2'b01) $display("FAIL midrst_tie: got %b/%b want 01/01", o_ready, o_rsp); else n_pass++;
    mdl_last = 0;
  endtask

  initial begin
    clk = 0; rst_n = 0; n_checks = 0; n_pass = 0; mdl_last = 1;
    bus.req_valid = 0; bus.req_addr = 0; bus.req_rw = 0; bus.req_wdata = 0;
    bus.m_busy = 0; bus.m_done = 0; bus.m_ack = 0; bus.m_rdata = 0;
    test_reset();
    test_basic_write();
    test_round_robin();
    test_busy_read();
    test_drop();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
